// File: rtl/sp_sqrt_pkg.sv
// Shared types, constants and special-operand decoding for the sequential
// single-precision square-root unit.
package sp_sqrt_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ITER  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] PINF     = 32'h7F80_0000;
    localparam int          EXP_BIAS = 127;

    localparam int ROOT_W = 25;
    localparam int RAD_W  = 50;
    localparam int REM_W  = 27;

    // Returns {invalid, result}; only meaningful when the operand is special
    // (negative, zero/subnormal, infinity or NaN).
    function automatic logic [32:0] special_result(input logic [31:0] x);
        logic [7:0]  e;
        logic [22:0] f;
        e = x[30:23];
        f = x[22:0];
        if (e == 8'hFF && f != 23'd0) return {~f[22], QNAN};
        if (e == 8'h00)               return {1'b0, x[31], 31'd0};
        if (x[31])                    return {1'b1, QNAN};
        return {1'b0, PINF};
    endfunction

endpackage

// File: rtl/sp_sqrt_seq_if.sv
// Operand/result handshake bundle. A transfer happens on a clock edge where
// valid and ready are both high; the producer holds data stable until then.
interface sp_sqrt_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic        out_invalid;
    logic        out_inexact;

    modport master (
        output in_valid, in_x, out_ready,
        input  in_ready, out_valid, out_y, out_invalid, out_inexact
    );

    modport slave (
        input  in_valid, in_x, out_ready,
        output in_ready, out_valid, out_y, out_invalid, out_inexact
    );
endinterface

// File: rtl/sp_sqrt_step.sv
// One restoring square-root step: brings down two radicand bits and
// resolves one root bit.
module sp_sqrt_step
    import sp_sqrt_pkg::*;
(
    input  logic [REM_W-1:0]  rem_i,
    input  logic [ROOT_W-1:0] root_i,
    input  logic [1:0]        bits_i,
    output logic [REM_W-1:0]  rem_o,
    output logic [ROOT_W-1:0] root_o
);
    logic              take;
    logic [REM_W-1:0]  trial;

    // The full-width compare decides the sign; the difference itself always
    // fits in REM_W bits when it is kept, so it is formed modulo 2^REM_W.
    assign take  = ({rem_i, bits_i} >= {2'b00, root_i, 2'b01});
    assign trial = {rem_i[REM_W-3:0], bits_i} - {root_i, 2'b01};

    always_comb begin
        rem_o  = {rem_i[REM_W-3:0], bits_i};
        root_o = {root_i[ROOT_W-2:0], 1'b0};
        if (take) begin
            rem_o  = trial;
            root_o = {root_i[ROOT_W-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/sp_sqrt_seq.sv
// Multi-cycle IEEE single sqrt: IDLE -> ITER (N cycles) -> ROUND -> DONE,
// with special operands going straight from IDLE to DONE.
module sp_sqrt_seq
    import sp_sqrt_pkg::*;
#(
    parameter int ITER_PER_CYC = 1
)
(
    input  logic         clk,
    input  logic         rst_n,
    sp_sqrt_seq_if.slave bus,
    output state_t       dbg_state_o
);
    localparam int         N        = ROOT_W / ITER_PER_CYC;
    localparam logic [4:0] CNT_LAST = 5'(N - 1);

    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [RAD_W-1:0]  rad_q, rad_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [ROOT_W-1:0] root_q, root_d;
    logic [7:0]        exp_q, exp_d;
    logic [31:0]       y_q, y_d;
    logic              inv_q, inv_d;
    logic              inx_q, inx_d;

    logic [REM_W-1:0]  rem_c  [ITER_PER_CYC+1];
    logic [ROOT_W-1:0] root_c [ITER_PER_CYC+1];

    logic              special;
    logic              sticky;
    logic              round_up;
    logic [23:0]       sig_rnd;

    assign rem_c[0]  = rem_q;
    assign root_c[0] = root_q;

    for (genvar i = 0; i < ITER_PER_CYC; i++) begin : g_step
        sp_sqrt_step u_step (
            .rem_i  (rem_c[i]),
            .root_i (root_c[i]),
            .bits_i (rad_q[RAD_W-1-2*i -: 2]),
            .rem_o  (rem_c[i+1]),
            .root_o (root_c[i+1])
        );
    end

    assign special  = bus.in_x[31] || (bus.in_x[30:23] == 8'h00) || (bus.in_x[30:23] == 8'hFF);
    assign sticky   = |rem_q;
    assign round_up = root_q[0] & (root_q[1] | sticky);
    assign sig_rnd  = root_q[ROOT_W-1:1] + {23'd0, round_up};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rad_d   = rad_q;
        rem_d   = rem_q;
        root_d  = root_q;
        exp_d   = exp_q;
        y_d     = y_q;
        inv_d   = inv_q;
        inx_d   = inx_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (special) begin
                        {inv_d, y_d} = special_result(bus.in_x);
                        inx_d        = 1'b0;
                        state_d      = S_DONE;
                    end else begin
                        // Odd biased exponent means an even true exponent.
                        rad_d   = bus.in_x[23] ? {2'b01, bus.in_x[22:0], 25'd0}
                                               : {1'b1, bus.in_x[22:0], 26'd0};
                        rem_d   = '0;
                        root_d  = '0;
                        cnt_d   = CNT_LAST;
                        exp_d   = 8'(({1'b0, bus.in_x[30:23]} + 9'(EXP_BIAS)) >> 1);
                        state_d = S_ITER;
                    end
                end
            end
            S_ITER: begin
                rem_d  = rem_c[ITER_PER_CYC];
                root_d = root_c[ITER_PER_CYC];
                rad_d  = rad_q << (2 * ITER_PER_CYC);
                cnt_d  = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    cnt_d   = 5'd0;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                // root_q[24] is always set, so a clear sig_rnd[23] can only
                // mean the rounding increment carried out of the significand.
                y_d     = {1'b0, exp_q + {7'd0, ~sig_rnd[23]}, sig_rnd[22:0]};
                inv_d   = 1'b0;
                inx_d   = root_q[0] | sticky;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            exp_q   <= '0;
            y_q     <= '0;
            inv_q   <= 1'b0;
            inx_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rad_q   <= rad_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            exp_q   <= exp_d;
            y_q     <= y_d;
            inv_q   <= inv_d;
            inx_q   <= inx_d;
        end
    end

    assign bus.in_ready    = (state_q == S_IDLE);
    assign bus.out_valid   = (state_q == S_DONE);
    assign bus.out_y       = y_q;
    assign bus.out_invalid = inv_q;
    assign bus.out_inexact = inx_q;
    assign dbg_state_o     = state_q;

endmodule
